// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
// Optional early-out path is enabled by defining DIV_EARLY_OUT_EN.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } div_state_e;

    localparam int MAX_WIDTH = 64;

    // Quotient reported for a zero divisor; sliced down to WIDTH by users.
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration:
// shift {rem, quo} left, trial-subtract the divisor, keep if non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned restoring divider sequencer for DIV/DIVU.
// Define DIV_EARLY_OUT_EN to finish in PREP when |a| < |b|.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    div_state_e state, state_n;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             sgn, q_neg, r_neg;
    logic             b_zero, early;

    assign abs_a  = (sgn && a_r[WIDTH-1]) ? (~a_r + 1'b1) : a_r;
    assign abs_b  = (sgn && b_r[WIDTH-1]) ? (~b_r + 1'b1) : b_r;
    assign b_zero = (b_r == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early = ~b_zero & (abs_a < abs_b);
`else
    assign early = 1'b0;
`endif

    assign stall = (start & (state == IDLE) & ~cancel) | busy;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = PREP;
            PREP: state_n = (b_zero || early) ? DONE : RUN;
            RUN:  if (cnt == '0) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A flush overrides everything, including a start in IDLE.
        if (cancel) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == PREP) || (state_n == RUN) || (state_n == FIX);
            done <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            sgn   <= 1'b0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_r <= a;
                b_r <= b;
                sgn <= is_signed;
            end
            if (state == PREP) begin
                rem   <= '0;
                quo   <= abs_a;
                dvs   <= abs_b;
                cnt   <= CW'(WIDTH - 1);
                q_neg <= sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                r_neg <= sgn & a_r[WIDTH-1];
            end
            if (state == RUN) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Results only change on a completed operation; a flush leaves them intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (!cancel) begin
            if (state == PREP && b_zero) begin
                quotient    <= DIV_ZERO_QUOT[WIDTH-1:0];
                remainder   <= a_r;
                div_by_zero <= 1'b1;
            end else if (state == PREP && early) begin
                quotient    <= '0;
                remainder   <= a_r;
                div_by_zero <= 1'b0;
            end else if (state == FIX) begin
                quotient    <= q_neg ? (~quo + 1'b1) : quo;
                remainder   <= r_neg ? (~rem + 1'b1) : rem;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (WIDTH=32).
// Early-out latency expectations follow DIV_EARLY_OUT_EN.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset, start, is_signed, cancel;
    logic [31:0] a, b;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 35;
`endif

    div_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .cancel      (cancel),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string tag,
                           input logic [31:0] da, input logic [31:0] db,
                           input logic sg,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic ez, input int lat, input bit noise);
        int n;
        int stall_lo;
        bit seen;
        start = 1'b1;
        a = da;
        b = db;
        is_signed = sg;
        #1;
        check({tag, ":stall0"}, stall, 1);
        step();
        start = 1'b0;
        n = 1;
        stall_lo = 0;
        seen = 0;
        while (n < 200) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (!stall) stall_lo++;
            if (noise) begin
                start = (n % 4 == 1);
                a = $urandom;
                b = $urandom_range(1, 9);
                is_signed = ~sg;
            end
            step();
            n++;
        end
        start = 1'b0;
        #1;
        check({tag, ":lat"}, seen ? n : 999, lat);
        check({tag, ":stall_lo"}, stall_lo, 0);
        check({tag, ":quot"}, quotient, eq);
        check({tag, ":rem"}, remainder, er);
        check({tag, ":dz"}, div_by_zero, ez);
        check({tag, ":stall_done"}, stall, 0);
        step();
        check({tag, ":done_pulse"}, done, 0);
        check({tag, ":busy_after"}, busy, 0);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1;
        start = 1'b0;
        cancel = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:quot", quotient, 0);
        check("rst:rem", remainder, 0);
        check("rst:dz", div_by_zero, 0);
        check("rst:stall", stall, 0);

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35, 0);
        run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35, 0);
        run_div("u-7_2", 32'hFFFF_FFF9, 32'd2, 1'b0,
                32'h7FFF_FFFC, 32'd1, 1'b0, 35, 0);
        run_div("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                32'h8000_0000, 32'd0, 1'b0, 35, 0);
        run_div("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
                32'hFFFF_FFFD, 32'd1, 1'b0, 35, 0);
        run_div("u3_10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, EO_LAT, 0);
        run_div("s-3_10", 32'hFFFF_FFFD, 32'd10, 1'b1,
                32'd0, 32'hFFFF_FFFD, 1'b0, EO_LAT, 0);
        run_div("u5_0", 32'd5, 32'd0, 1'b0,
                32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0);

        // Flush mid-run: prior divide-by-zero results must survive.
        start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        is_signed = 1'b0;
        step();
        start = 1'b0;
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        #1;
        check("cxl:busy", busy, 0);
        check("cxl:done", done, 0);
        check("cxl:stall", stall, 0);
        check("cxl:quot", quotient, 32'hFFFF_FFFF);
        check("cxl:rem", remainder, 32'd5);
        check("cxl:dz", div_by_zero, 1);
        run_div("u9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 35, 0);

        // Cancel together with start in IDLE drops the start.
        start = 1'b1;
        cancel = 1'b1;
        a = 32'd10;
        b = 32'd3;
        #1;
        check("cxs:stall", stall, 0);
        step();
        start = 1'b0;
        cancel = 1'b0;
        check("cxs:busy", busy, 0);
        dcnt = 0;
        repeat (40) begin
            step();
            if (done) dcnt++;
        end
        check("cxs:dones", dcnt, 0);
        check("cxs:quot", quotient, 32'd2);

        // Starts and operand changes while busy are ignored.
        run_div("noise", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 35, 1);

        // Reset in the middle of a run.
        start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        is_signed = 1'b0;
        step();
        start = 1'b0;
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst:busy", busy, 0);
        check("mrst:done", done, 0);
        check("mrst:quot", quotient, 0);
        check("mrst:rem", remainder, 0);
        check("mrst:dz", div_by_zero, 0);
        dcnt = 0;
        repeat (40) begin
            step();
            if (done) dcnt++;
        end
        check("mrst:dones", dcnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
